// File: rtl/shift_reg_mem_collect_pkg.sv
// Types shared by both ends of the shift memory stream so that the two ends
// agree on element width and lane order.
package shift_mem_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef logic signed [DATA_W-1:0] elem_t;
  typedef elem_t [DEPTH-1:0] vec_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    FULL = 2'd2
  } collect_state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

endpackage

// File: rtl/shift_reg_mem_collect_if.sv
// Stream-in / vector-out bundle of the collector; the slave side is the collector.
interface shift_reg_mem_collect_if;
  import shift_mem_pkg::*;

  elem_t            in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  vec_t             read_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_padded;
  logic [CNT_W-1:0] fill_count;

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, read_data, out_valid, out_padded, fill_count
  );

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, read_data, out_valid, out_padded, fill_count
  );

endinterface

// File: rtl/shift_reg_mem_collect_comb.sv
// Next-lane function: shifts lane i-1 into lane i and inserts either the
// incoming element or a zero pad at lane 0.
module shift_reg_mem_collect_comb
  import shift_mem_pkg::*;
(
  input  vec_t  lanes_i,
  input  elem_t in_data_i,
  input  logic  shift_en_i,
  input  logic  pad_sel_i,
  output vec_t  lanes_o
);

  // Shift or hold the lane vector.
  always_comb begin
    lanes_o = lanes_i;
    if (shift_en_i) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        lanes_o[i] = lanes_i[i-1];
      end
      if (pad_sel_i) begin
        lanes_o[0] = {DATA_W{1'b0}};
      end else begin
        lanes_o[0] = in_data_i;
      end
    end else begin
      lanes_o = lanes_i;
    end
  end

endmodule

// File: rtl/shift_reg_mem_collect.sv
// Serial-to-parallel collector: gathers DEPTH signed elements into a vector,
// optionally zero-padding a partial vector on flush.
module shift_reg_mem_collect
  import shift_mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  shift_reg_mem_collect_if.slave bus
);

  collect_state_e   state_q, state_d;
  vec_t             lanes_q, lanes_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             padded_q, padded_d;
  logic             shift_en_s, pad_sel_s;
  logic             in_ready_s, out_valid_s;
  logic             accept_s, consume_s;

  shift_reg_mem_collect_comb u_comb (
    .lanes_i    (lanes_q),
    .in_data_i  (bus.in_data),
    .shift_en_i (shift_en_s),
    .pad_sel_i  (pad_sel_s),
    .lanes_o    (lanes_d)
  );

  // FULL forwards out_ready as in_ready so a new vector can start on the consume cycle.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = (state_q == FULL);
    case (state_q)
      FILL:    in_ready_s = 1'b1;
      PAD:     in_ready_s = 1'b0;
      FULL:    in_ready_s = bus.out_ready;
      default: in_ready_s = 1'b0;
    endcase
  end

  assign accept_s  = bus.in_valid & in_ready_s;
  assign consume_s = out_valid_s & bus.out_ready;

  // Next state, fill counter, pad flag and shift control.
  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    padded_d   = padded_q;
    shift_en_s = 1'b0;
    pad_sel_s  = 1'b0;
    case (state_q)
      FILL: begin
        if (accept_s) begin
          shift_en_s = 1'b1;
          fill_d     = fill_q + CNT_ONE;
          if (fill_q == CNT_LAST) begin
            state_d  = FULL;
            padded_d = 1'b0;
          end else if (bus.flush) begin
            state_d  = PAD;
            padded_d = 1'b1;
          end else begin
            state_d = FILL;
          end
        end else if (bus.flush && (fill_q != CNT_ZERO)) begin
          state_d  = PAD;
          padded_d = 1'b1;
        end else begin
          state_d = FILL;
        end
      end
      PAD: begin
        shift_en_s = 1'b1;
        pad_sel_s  = 1'b1;
        fill_d     = fill_q + CNT_ONE;
        if (fill_q == CNT_LAST) begin
          state_d = FULL;
        end else begin
          state_d = PAD;
        end
      end
      FULL: begin
        // Lanes above 0 may shift here; they are refilled before the next FULL.
        if (consume_s) begin
          state_d  = FILL;
          padded_d = 1'b0;
          if (accept_s) begin
            shift_en_s = 1'b1;
            fill_d     = CNT_ONE;
          end else begin
            fill_d = CNT_ZERO;
          end
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d  = FILL;
        fill_d   = CNT_ZERO;
        padded_d = 1'b0;
      end
    endcase
  end

  // State, lane and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      lanes_q  <= '0;
      fill_q   <= CNT_ZERO;
      padded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lanes_q  <= lanes_d;
      fill_q   <= fill_d;
      padded_q <= padded_d;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_s;
  assign bus.read_data  = lanes_q;
  assign bus.out_padded = padded_q;
  assign bus.fill_count = fill_q;

endmodule
